// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//
// Drains a synchronous FIFO one word at a time and sends each word on a
// serial line as an asynchronous UART frame: one start bit (0), SIZE data
// bits LSB first, an optional even-parity bit, then STOP_BITS stop bits (1).
//
// Parameters
//   SIZE       data word width (matches the FIFO word width)
//   DIV        tsCLOCK cycles per serial bit, >= 2
//   STOP_BITS  stop bits per frame, 1 or 2
//
// Ports
//   tsCLOCK    in   rising-edge clock
//   tsRESET_N  in   asynchronous reset, active low
//   CLEAR_N    in   synchronous clear, active low, same effect as reset
//   ENABLE     in   allows new frames to be started
//   F_EMPTY_N  in   FIFO not-empty flag, only looked at in IDLE
//   FIFO_DATA  in   FIFO read data, valid the cycle after READ
//   READ       out  one-cycle FIFO pop request
//   TX         out  serial line, idles high
//   BUSY       out  high from the pop until the last stop bit has been sent
//
// Configuration
//   FIFO_UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the data
//                           bits) is sent between the data and stop bits.

module fifo_uart_tx #(
    parameter int SIZE      = 8,
    parameter int DIV       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic            tsCLOCK,
    input  logic            tsRESET_N,
    input  logic            CLEAR_N,
    input  logic            ENABLE,
    input  logic            F_EMPTY_N,
    input  logic [SIZE-1:0] FIFO_DATA,
    output logic            READ,
    output logic            TX,
    output logic            BUSY
);

    localparam int BAUD_W = $clog2(DIV);
    localparam int CNT_W  = $clog2(SIZE + 2);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [SIZE-1:0]   shift_q, shift_d;
    logic              bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge tsCLOCK or negedge tsRESET_N) begin
        if (!tsRESET_N) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // bit_q counts data bits in DATA and stop bits in STOP; it is always
    // zero on entry to either state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        bit_end = (baud_q == BAUD_LAST);

        if (state_q != IDLE && state_q != POP && state_q != WAIT) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ENABLE && F_EMPTY_N) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = WAIT;
            end
            WAIT: begin
                shift_d = FIFO_DATA;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^FIFO_DATA;
`endif
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The baud counter restarts with every new state so each phase
        // starts on a fresh bit period.
        if (state_d != state_q) begin
            baud_d = '0;
        end

        // Clear abandons everything, including a frame mid-flight.
        if (!CLEAR_N) begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_d   = 1'b0;
`endif
        end
    end

    // Outputs are decoded from registered state only, so they are glitch
    // free relative to the inputs.
    always_comb begin
        READ = (state_q == POP);
        BUSY = (state_q != IDLE);
        case (state_q)
            START:   TX = 1'b0;
            DATA:    TX = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PAR:     TX = par_q;
`endif
            default: TX = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx (SIZE=8, DIV=4). A second instance with
// STOP_BITS=2 covers the longer stop phase. A small FIFO model feeds the
// main instance; expected serial frames are rebuilt from each data word.

module tb_fifo_uart_tx;

    localparam int DIV = 4;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       clear_n = 1'b1;
    logic       enable = 1'b0;
    logic       f_empty_n;
    logic [7:0] fifo_data = 8'h00;
    logic       read, tx, busy;

    logic       f2 = 1'b0;
    logic       en2 = 1'b0;
    logic [7:0] fifo_data2 = 8'h00;
    logic       read2, tx2, busy2;

    int vectors = 0;
    int miscompares = 0;
    int read_cnt = 0;

    logic [7:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;

    always #5 clock = ~clock;

    fifo_uart_tx #(.SIZE(8), .DIV(DIV), .STOP_BITS(1)) dut (
        .tsCLOCK   (clock),
        .tsRESET_N (reset_n),
        .CLEAR_N   (clear_n),
        .ENABLE    (enable),
        .F_EMPTY_N (f_empty_n),
        .FIFO_DATA (fifo_data),
        .READ      (read),
        .TX        (tx),
        .BUSY      (busy)
    );

    fifo_uart_tx #(.SIZE(8), .DIV(DIV), .STOP_BITS(2)) dut2 (
        .tsCLOCK   (clock),
        .tsRESET_N (reset_n),
        .CLEAR_N   (1'b1),
        .ENABLE    (en2),
        .F_EMPTY_N (f2),
        .FIFO_DATA (fifo_data2),
        .READ      (read2),
        .TX        (tx2),
        .BUSY      (busy2)
    );

    // FIFO model: a pop presents the next word on the following cycle.
    assign f_empty_n = (wr_ptr != rd_ptr);

    always @(posedge clock) begin
        if (read && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
        if (read) begin
            read_cnt <= read_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        mem[wr_ptr % 16] = word;
        wr_ptr = wr_ptr + 1;
    endtask

    // Steps negedges until READ is seen; cycles is how many it took.
    task automatic waitForRead(output int cycles);
        cycles = 0;
        while (!read && cycles < 60) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput("read_seen", 32'(read), 32'd1);
    endtask

    // Called at the negedge where READ is high (POP). Checks the two idle-high
    // cycles of POP and WAIT, then the whole frame cycle by cycle, and ends at
    // the negedge right after the last stop cycle.
    task automatic checkFrame(input logic [7:0] word, input int drop_at);
        logic exp_bits [0:15];
        int   nbits;
        nbits = 1 + 8 + PBITS + 1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = word[i];
        if (PBITS == 1) exp_bits[9] = ^word;
        exp_bits[nbits - 1] = 1'b1;

        checkOutput("tx_pop", 32'(tx), 32'd1);
        @(negedge clock);
        checkOutput("tx_wait", 32'(tx), 32'd1);
        checkOutput("read_wait", 32'(read), 32'd0);
        @(negedge clock);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < DIV; c++) begin
                if (b * DIV + c == drop_at) enable = 1'b0;
                checkOutput($sformatf("tx_bit%0d_c%0d", b, c), 32'(tx), 32'(exp_bits[b]));
                if (c == 0) checkOutput($sformatf("busy_bit%0d", b), 32'(busy), 32'd1);
                @(negedge clock);
            end
        end
        checkOutput("busy_end", 32'(busy), 32'd0);
        checkOutput("tx_end", 32'(tx), 32'd1);
    endtask

    initial begin
        int cyc;
        int rc0;
        int n;
        int hi;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_read", 32'(read), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // 0xA5: latency, single pop, frame shape
        enable = 1'b1;
        rc0 = read_cnt;
        applyStimulus(8'hA5);
        waitForRead(cyc);
        checkOutput("latency_a5", 32'(cyc), 32'd1);
        checkFrame(8'hA5, -1);
        checkOutput("reads_a5", 32'(read_cnt - rc0), 32'd1);

        // 0x01: parity bit 1 when parity is present
        applyStimulus(8'h01);
        waitForRead(cyc);
        checkFrame(8'h01, -1);

        // 0x00 then 0xFF back to back: 3-cycle idle-high gap
        rc0 = read_cnt;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        waitForRead(cyc);
        checkFrame(8'h00, -1);
        checkOutput("gap_read_idle", 32'(read), 32'd0);
        @(negedge clock);
        checkOutput("gap_read_pop", 32'(read), 32'd1);
        checkFrame(8'hFF, -1);
        checkOutput("reads_pair", 32'(read_cnt - rc0), 32'd2);

        // ENABLE dropped during the 5th data bit
        applyStimulus(8'h3C);
        applyStimulus(8'h5A);
        waitForRead(cyc);
        checkFrame(8'h3C, (1 + 4) * DIV + 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("read_disabled", 32'(read), 32'd0);
            @(negedge clock);
        end
        enable = 1'b1;
        waitForRead(cyc);
        checkOutput("resume_latency", 32'(cyc), 32'd1);
        checkFrame(8'h5A, -1);

        // CLEAR_N during WAIT drops the word in flight
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        waitForRead(cyc);
        @(negedge clock);
        clear_n = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        checkOutput("clr_tx", 32'(tx), 32'd1);
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_read", 32'(read), 32'd0);
        @(negedge clock);
        checkOutput("clr_next_read", 32'(read), 32'd1);
        checkFrame(8'h22, -1);

        // Reset pulse mid-frame
        applyStimulus(8'h77);
        waitForRead(cyc);
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_tx", 32'(tx), 32'd1);
        checkOutput("mid_rst_read", 32'(read), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checkOutput("post_rst_read", 32'(read), 32'd0);
            checkOutput("post_rst_busy", 32'(busy), 32'd0);
        end
        applyStimulus(8'h0F);
        waitForRead(cyc);
        checkOutput("post_rst_latency", 32'(cyc), 32'd1);
        checkFrame(8'h0F, -1);

        // STOP_BITS=2 instance, word 0x00: TX high only in POP, WAIT and stop
        enable = 1'b0;
        en2 = 1'b1;
        f2 = 1'b1;
        n = 0;
        while (!read2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("stop2_read", 32'(read2), 32'd1);
        f2 = 1'b0;
        en2 = 1'b0;
        n = 0;
        hi = 0;
        while (busy2 && n < 200) begin
            n++;
            if (tx2) hi++;
            @(negedge clock);
        end
        checkOutput("stop2_busy_len", 32'(n), 32'(2 + (1 + 8 + PBITS + 2) * DIV));
        checkOutput("stop2_high_cycles", 32'(hi), 32'(2 + 2 * DIV));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
